memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameters: none; widths come from shared constants `WORD (32) and `REG_SIZE (5).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 ALUResultM, writeDataM, pcM  in  `WORD  from execute register: address or ALU result, store data, and PC.
REQ-005 writeRegM  in  `REG_SIZE  destination register.
REQ-006 regWriteM, memWriteM, mem2regM, branchM, zeroM, finishM, validM  in  1  control bits from the execute register.
REQ-007 dmemReq  out  1  data-memory request valid.
REQ-008 dmemWe  out  1  1 means store, 0 means load.
REQ-009 dmemAddr, dmemWdata  out  `WORD  request address and store data.
REQ-010 dmemReady  in  1  memory accepts the request this cycle.
REQ-011 dmemRvalid  in  1  load data valid this cycle.
REQ-012 dmemRdata  in  `WORD  load data.
REQ-013 stallM  out  1  hold the execute register and upstream stages this cycle; the M inputs must stay stable while it is high.
REQ-014 branchTakenM  out  1  equals branchM & zeroM & validM.
REQ-015 resultW, pcW  out  `WORD  writeback result and PC.
REQ-016 writeRegW  out  `REG_SIZE  writeback destination register.
REQ-017 regWriteW, finishW, validW, misalignW  out  1  writeback controls and the misaligned-access fault flag.

Function
REQ-018 FSM states are IDLE, REQ and WAIT_RD.
REQ-019 A memory op is validM & (memWriteM | mem2regM).
REQ-020 Non-memory op, or validM=0: the W register loads the M fields at the next edge with stallM=0, so latency is 1 cycle.
REQ-021 resultW is dmemRdata when mem2regM is set, otherwise ALUResultM.
REQ-022 Accesses are word-only; an access is misaligned when ALUResultM[1:0] != 0.
REQ-023 A misaligned memory op issues no request, completes in 1 cycle with misalignW=1 and regWriteW=0, and keeps validW=1.
REQ-024 dmemReq is asserted in IDLE (aligned memory op present) and in REQ; it is never asserted in WAIT_RD.
REQ-025 dmemAddr=ALUResultM, dmemWdata=writeDataM and dmemWe=memWriteM, held stable until accept.
REQ-026 Accept is dmemReq & dmemReady in the same cycle.
REQ-027 Store: completes in its accept cycle, with stallM=0 in that cycle and the W register loaded at that edge.
REQ-028 Store: a store with dmemReady already high therefore costs 1 cycle.
REQ-029 Load: stallM=1 in the accept cycle, then the FSM enters WAIT_RD.
REQ-030 Load: in WAIT_RD, stallM = ~dmemRvalid; the W register loads when dmemRvalid is high, and the FSM then returns to IDLE.
REQ-031 Minimum load latency is 2 cycles.
REQ-032 No accept: the FSM goes IDLE->REQ with stallM=1, and stays in REQ until accept.
REQ-033 While stallM=1 the W register loads a bubble: validW=0, regWriteW=0, finishW=0, misalignW=0.
REQ-034 dmemRvalid outside WAIT_RD is ignored; dmemRvalid in the same cycle as accept is a protocol violation and is not honored.
REQ-035 memWriteM and mem2regM both set is treated as a store.
REQ-036 With stallM=0, a back-to-back memory op may issue its request in the cycle after completion.

Reset
REQ-037 On reset assertion, state goes to IDLE immediately (asynchronously) and dmemReq drops combinationally.
REQ-038 On reset, all W outputs clear to 0 and validW=0.
REQ-039 A reset during REQ or WAIT_RD abandons the op; any dmemRvalid arriving after reset is ignored.
REQ-040 stallM=0 while reset is high.

Structure
REQ-041 `WORD, `REG_SIZE and the FSM state enum live in the shared CPU package/defines.
REQ-042 The W pipeline register reuses the existing flopr parameterized register; no other sub-modules.

Verification
REQ-043 ALU op: ALUResultM=0x10, regWriteM=1, writeRegM=5, validM=1 -> next cycle resultW=0x10, writeRegW=5, validW=1, stallM never high.
REQ-044 Store with dmemReady held low 3 cycles: addr 0x100, data 0xDEADBEEF.
  - dmemReq stays high with stable addr/data.
  - stallM=1 for 3 cycles, then validW=1 after accept.
REQ-045 Load from 0x200: ready=1, rvalid 2 cycles after accept with 0xCAFEF00D.
  - stallM is high for 3 cycles.
  - resultW=0xCAFEF00D.
  - During stall, validW=0.
REQ-046 Load with ALUResultM=0x202 -> no dmemReq, misalignW=1, regWriteW=0, 1-cycle latency.
REQ-047 Reset asserted in WAIT_RD, then rvalid pulses -> dmemReq=0 immediately, state IDLE, all W outputs 0, the pulse is ignored.
REQ-048 branchM=1, zeroM=1, validM=1 -> branchTakenM=1 in the same cycle; with validM=0 -> branchTakenM=0.

Source files
------------

// File: rtl/memory_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage_pkg
// Brief    : Shared widths and memory-stage FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package memory_stage_pkg;

    localparam int WORD     = 32;
    localparam int REG_SIZE = 5;

    // resultW + pcW + writeRegW + {regWriteW, finishW, validW, misalignW}
    localparam int WB_WIDTH = 2 * WORD + REG_SIZE + 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/memory_stage_flopr.sv
`default_nettype none
// ============================================================================
// Module   : flopr
// Brief    : Parameterized register with asynchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_q <= '0;
        end else begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Brief    : Pipeline memory stage: data-memory handshake FSM and W register.
// Revision : 1.0 - initial release
// ============================================================================
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD-1:0]     ALUResultM,
    input  logic [WORD-1:0]     writeDataM,
    input  logic [WORD-1:0]     pcM,
    input  logic [REG_SIZE-1:0] writeRegM,
    input  logic                regWriteM,
    input  logic                memWriteM,
    input  logic                mem2regM,
    input  logic                branchM,
    input  logic                zeroM,
    input  logic                finishM,
    input  logic                validM,
    output logic                dmemReq,
    output logic                dmemWe,
    output logic [WORD-1:0]     dmemAddr,
    output logic [WORD-1:0]     dmemWdata,
    input  logic                dmemReady,
    input  logic                dmemRvalid,
    input  logic [WORD-1:0]     dmemRdata,
    output logic                stallM,
    output logic                branchTakenM,
    output logic [WORD-1:0]     resultW,
    output logic [WORD-1:0]     pcW,
    output logic [REG_SIZE-1:0] writeRegW,
    output logic                regWriteW,
    output logic                finishW,
    output logic                validW,
    output logic                misalignW
);

    mem_state_t            r_state;
    mem_state_t            w_next_state;
    logic                  w_mem_op;
    logic                  w_misalign;
    logic                  w_aligned_op;
    logic                  w_fault;
    logic                  w_store;
    logic                  w_req;
    logic                  w_stall;
    logic [WORD-1:0]       w_result;
    logic [WB_WIDTH-1:0]   w_wb_d;
    logic [WB_WIDTH-1:0]   w_wb_q;

    assign w_mem_op     = validM & (memWriteM | mem2regM);
    assign w_misalign   = (ALUResultM[1:0] != 2'b00);
    assign w_aligned_op = w_mem_op & ~w_misalign;
    assign w_fault      = w_mem_op & w_misalign;
    // memWriteM wins when both memWriteM and mem2regM are set
    assign w_store      = memWriteM;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_aligned_op) begin
                    w_req = 1'b1;
                    if (!dmemReady) begin
                        w_stall      = 1'b1;
                        w_next_state = REQ;
                    end else if (!w_store) begin
                        w_stall      = 1'b1;
                        w_next_state = WAIT_RD;
                    end
                end
            end
            REQ: begin
                w_req = 1'b1;
                if (!dmemReady) begin
                    w_stall = 1'b1;
                end else if (!w_store) begin
                    w_stall      = 1'b1;
                    w_next_state = WAIT_RD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WAIT_RD: begin
                w_stall = ~dmemRvalid;
                if (dmemRvalid) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // Request and stall must fall with reset, not wait for the next edge
        if (reset) begin
            w_req   = 1'b0;
            w_stall = 1'b0;
        end
    end

    assign w_result = mem2regM ? dmemRdata : ALUResultM;

    // A stalled cycle writes a bubble: data fields pass through, controls clear
    assign w_wb_d = {w_result,
                     pcM,
                     writeRegM,
                     regWriteM & ~w_fault & ~w_stall,
                     finishM & ~w_stall,
                     validM & ~w_stall,
                     w_fault & ~w_stall};

    flopr #(
        .WIDTH (WB_WIDTH)
    ) u_wb_reg (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_wb_d),
        .o_q   (w_wb_q)
    );

    assign {resultW, pcW, writeRegW, regWriteW, finishW, validW, misalignW} = w_wb_q;

    assign dmemReq      = w_req;
    assign dmemWe       = memWriteM;
    assign dmemAddr     = ALUResultM;
    assign dmemWdata    = writeDataM;
    assign stallM       = w_stall;
    assign branchTakenM = branchM & zeroM & validM;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_stage
// Brief    : Self-checking bench for memory_stage (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultM, writeDataM, pcM, dmemAddr, dmemWdata, dmemRdata;
    logic [31:0] resultW, pcW;
    logic [4:0]  writeRegM, writeRegW;
    logic        regWriteM, memWriteM, mem2regM, branchM, zeroM, finishM, validM;
    logic        dmemReq, dmemWe, dmemReady, dmemRvalid, stallM, branchTakenM;
    logic        regWriteW, finishW, validW, misalignW;

    int n_tot = 0;
    int n_bad = 0;
    int n_stall;

    typedef struct {
        logic [31:0] alu, wdata, pc;
        logic [4:0]  wreg;
        logic        rw, mw, m2r, br, zr, fin, vld, rdy;
        logic        e_req, e_stall, e_bt;
        logic [31:0] e_res, e_pc;
        logic [4:0]  e_wreg;
        logic        e_rw, e_fin, e_vld, e_mis;
    } vec_t;

    vec_t vecs[10];

    memory_stage dut (
        .clk          (clk),
        .reset        (reset),
        .ALUResultM   (ALUResultM),
        .writeDataM   (writeDataM),
        .pcM          (pcM),
        .writeRegM    (writeRegM),
        .regWriteM    (regWriteM),
        .memWriteM    (memWriteM),
        .mem2regM     (mem2regM),
        .branchM      (branchM),
        .zeroM        (zeroM),
        .finishM      (finishM),
        .validM       (validM),
        .dmemReq      (dmemReq),
        .dmemWe       (dmemWe),
        .dmemAddr     (dmemAddr),
        .dmemWdata    (dmemWdata),
        .dmemReady    (dmemReady),
        .dmemRvalid   (dmemRvalid),
        .dmemRdata    (dmemRdata),
        .stallM       (stallM),
        .branchTakenM (branchTakenM),
        .resultW      (resultW),
        .pcW          (pcW),
        .writeRegW    (writeRegW),
        .regWriteW    (regWriteW),
        .finishW      (finishW),
        .validW       (validW),
        .misalignW    (misalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clr_m();
        ALUResultM = 32'h0; writeDataM = 32'h0; pcM = 32'h0; writeRegM = 5'd0;
        regWriteM = 1'b0; memWriteM = 1'b0; mem2regM = 1'b0; branchM = 1'b0;
        zeroM = 1'b0; finishM = 1'b0; validM = 1'b0;
        dmemReady = 1'b0; dmemRvalid = 1'b0; dmemRdata = 32'h0;
    endtask

    task automatic set_mem(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                           input logic [4:0] wr, input logic rw, input logic mw, input logic m2r);
        ALUResultM = alu; writeDataM = wd; pcM = pc; writeRegM = wr;
        regWriteM = rw; memWriteM = mw; mem2regM = m2r; validM = 1'b1;
    endtask

    initial begin
        //          alu       wdata     pc        wreg  rw   mw   m2r  br   zr   fin  vld  rdy   req  stl  bt    res       pc        wreg  rw   fin  vld  mis
        vecs[0] = '{32'h010, 32'h000, 32'h100, 5'd5, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 32'h010, 32'h100, 5'd5, 1'b1,1'b0,1'b1,1'b0};
        vecs[1] = '{32'h004, 32'h000, 32'h104, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1, 32'h004, 32'h104, 5'd0, 1'b0,1'b0,1'b1,1'b0};
        vecs[2] = '{32'h008, 32'h000, 32'h108, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 32'h008, 32'h108, 5'd0, 1'b0,1'b0,1'b0,1'b0};
        vecs[3] = '{32'h00C, 32'h000, 32'h10C, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 32'h00C, 32'h10C, 5'd0, 1'b0,1'b0,1'b1,1'b0};
        vecs[4] = '{32'h202, 32'h000, 32'h110, 5'd7, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 32'h000, 32'h110, 5'd7, 1'b0,1'b0,1'b1,1'b1};
        vecs[5] = '{32'h101, 32'h055, 32'h114, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 32'h101, 32'h114, 5'd0, 1'b0,1'b0,1'b1,1'b1};
        vecs[6] = '{32'h040, 32'h1234,32'h118, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0, 32'h040, 32'h118, 5'd0, 1'b0,1'b0,1'b1,1'b0};
        vecs[7] = '{32'h000, 32'h000, 32'h11C, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 32'h000, 32'h11C, 5'd0, 1'b0,1'b1,1'b1,1'b0};
        vecs[8] = '{32'h300, 32'h000, 32'h120, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 32'h300, 32'h120, 5'd0, 1'b0,1'b0,1'b0,1'b0};
        vecs[9] = '{32'h044, 32'h077, 32'h124, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0, 32'h000, 32'h124, 5'd0, 1'b0,1'b0,1'b1,1'b0};

        // Reset state
        clr_m();
        reset = 1'b1;
        #1;
        chk("rst.req",    32'(dmemReq), 32'h0);
        chk("rst.stall",  32'(stallM),  32'h0);
        chk("rst.validW", 32'(validW),  32'h0);
        chk("rst.resultW", resultW,     32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single-cycle vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clr_m();
            ALUResultM = vecs[i].alu; writeDataM = vecs[i].wdata; pcM = vecs[i].pc;
            writeRegM = vecs[i].wreg; regWriteM = vecs[i].rw; memWriteM = vecs[i].mw;
            mem2regM = vecs[i].m2r; branchM = vecs[i].br; zeroM = vecs[i].zr;
            finishM = vecs[i].fin; validM = vecs[i].vld; dmemReady = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d.req", i),   32'(dmemReq),      32'(vecs[i].e_req));
            chk($sformatf("v%0d.stall", i), 32'(stallM),       32'(vecs[i].e_stall));
            chk($sformatf("v%0d.bt", i),    32'(branchTakenM), 32'(vecs[i].e_bt));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d.addr", i), dmemAddr,     vecs[i].alu);
                chk($sformatf("v%0d.we", i),   32'(dmemWe),  32'(vecs[i].mw));
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.resultW", i),  resultW,         vecs[i].e_res);
            chk($sformatf("v%0d.pcW", i),      pcW,             vecs[i].e_pc);
            chk($sformatf("v%0d.writeRegW", i), 32'(writeRegW), 32'(vecs[i].e_wreg));
            chk($sformatf("v%0d.regWriteW", i), 32'(regWriteW), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d.finishW", i),  32'(finishW),    32'(vecs[i].e_fin));
            chk($sformatf("v%0d.validW", i),   32'(validW),     32'(vecs[i].e_vld));
            chk($sformatf("v%0d.misalignW", i), 32'(misalignW), 32'(vecs[i].e_mis));
        end

        // Store held off by dmemReady low for 3 cycles
        @(negedge clk);
        clr_m();
        set_mem(32'h100, 32'hDEADBEEF, 32'h200, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st%0d.req", c),   32'(dmemReq), 32'h1);
            chk($sformatf("st%0d.addr", c),  dmemAddr,     32'h100);
            chk($sformatf("st%0d.wdata", c), dmemWdata,    32'hDEADBEEF);
            chk($sformatf("st%0d.stall", c), 32'(stallM),  32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("st%0d.validW", c), 32'(validW), 32'h0);
            @(negedge clk);
        end
        dmemReady = 1'b1;
        #1;
        chk("st.acc.req",   32'(dmemReq), 32'h1);
        chk("st.acc.stall", 32'(stallM),  32'h0);
        @(posedge clk);
        #1;
        chk("st.validW",  32'(validW), 32'h1);
        chk("st.resultW", resultW,     32'h100);

        // Load from 0x200: accept, two empty wait cycles, then data
        @(negedge clk);
        clr_m();
        set_mem(32'h200, 32'h0, 32'h204, 5'd9, 1'b1, 1'b0, 1'b1);
        dmemReady  = 1'b1;
        dmemRvalid = 1'b1;            // same-cycle rvalid must not complete the load
        dmemRdata  = 32'h11111111;
        n_stall    = 0;
        #1;
        chk("ld.acc.req", 32'(dmemReq), 32'h1);
        chk("ld.acc.we",  32'(dmemWe),  32'h0);
        if (stallM) n_stall++;
        @(posedge clk);
        #1;
        chk("ld.acc.validW", 32'(validW), 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            dmemReady  = 1'b0;
            dmemRvalid = 1'b0;
            #1;
            chk($sformatf("ld.w%0d.req", c), 32'(dmemReq), 32'h0);
            if (stallM) n_stall++;
            @(posedge clk);
            #1;
            chk($sformatf("ld.w%0d.validW", c), 32'(validW), 32'h0);
        end
        @(negedge clk);
        dmemRvalid = 1'b1;
        dmemRdata  = 32'hCAFEF00D;
        #1;
        chk("ld.rv.stall", 32'(stallM), 32'h0);
        if (stallM) n_stall++;
        chk("ld.stall_cycles", 32'(n_stall), 32'd3);
        @(posedge clk);
        #1;
        chk("ld.resultW",   resultW,         32'hCAFEF00D);
        chk("ld.validW",    32'(validW),     32'h1);
        chk("ld.regWriteW", 32'(regWriteW),  32'h1);
        chk("ld.writeRegW", 32'(writeRegW),  32'd9);

        // Reset while in WAIT_RD, then stray rvalid
        @(negedge clk);
        clr_m();
        set_mem(32'h300, 32'h0, 32'h208, 5'd3, 1'b1, 1'b0, 1'b1);
        dmemReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmemReady = 1'b0;
        #1;
        chk("rw.wait.req",   32'(dmemReq), 32'h0);
        chk("rw.wait.stall", 32'(stallM),  32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rw.req",       32'(dmemReq),   32'h0);
        chk("rw.stall",     32'(stallM),    32'h0);
        chk("rw.validW",    32'(validW),    32'h0);
        chk("rw.regWriteW", 32'(regWriteW), 32'h0);
        chk("rw.pcW",       pcW,            32'h0);
        dmemRvalid = 1'b1;
        dmemRdata  = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        chk("rw.held.resultW", resultW,     32'h0);
        chk("rw.held.validW",  32'(validW), 32'h0);
        @(negedge clk);
        reset = 1'b0;                 // load still presented, rvalid still high
        #1;
        chk("rw.post.req",   32'(dmemReq), 32'h1);
        chk("rw.post.stall", 32'(stallM),  32'h1);
        @(posedge clk);
        #1;
        chk("rw.post.validW", 32'(validW), 32'h0);
        @(negedge clk);
        dmemRvalid = 1'b0;
        dmemReady  = 1'b1;
        #1;
        chk("rw.re.stall", 32'(stallM), 32'h1);
        @(posedge clk);
        @(negedge clk);
        dmemReady  = 1'b0;
        dmemRvalid = 1'b1;
        dmemRdata  = 32'hABCD0000;
        #1;
        chk("rw.re.done", 32'(stallM), 32'h0);
        @(posedge clk);
        #1;
        chk("rw.re.resultW", resultW,     32'hABCD0000);
        chk("rw.re.validW",  32'(validW), 32'h1);
        @(negedge clk);
        clr_m();
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
